// File: rtl/i2s_rx_capture.sv
// i2s_rx_capture: I2S ADC receiver; synchronizes SCLK/LRCLK/SDIN, deserializes L/R slots into a stereo-frame FIFO with valid/ready output.
// Optional macro I2S_RX_FRAME_CTR_EN adds the 16-bit frame_ctr port counting successful pushes.
module i2s_rx_capture #(
    parameter int SAMPLE_W   = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                MAX10_CLK1_50,
    input  logic                reset,
    input  logic                enable,
    input  logic                sclk,
    input  logic                lrclk,
    input  logic                sdin,
    input  logic                ready,
    input  logic                clear_ovr,
    output logic [SAMPLE_W-1:0] sample_l,
    output logic [SAMPLE_W-1:0] sample_r,
    output logic                valid,
    output logic                overrun
`ifdef I2S_RX_FRAME_CTR_EN
    ,
    output logic [15:0]         frame_ctr
`endif
);
    localparam int CNT_W = $clog2(SAMPLE_W + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, SKIP_L, LEFT, SKIP_R, RIGHT} state_t;
    state_t state, state_nxt;

    logic [2:0]          sclk_s, lrclk_s;
    logic [1:0]          sdin_s;
    logic                sclk_rise, lr_rise, lr_fall, bit_in;
    logic                slot_start, latch_l, latch_r, shift_en;
    logic [SAMPLE_W-1:0] shreg, left_q, right_q;
    logic [CNT_W-1:0]    bit_cnt, bit_pos;
    logic                push_q;

    logic [SAMPLE_W-1:0] mem_l [FIFO_DEPTH];
    logic [SAMPLE_W-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [PTR_W:0]      count;
    logic                full, pop, push_ok;

    // SDIN gets one flop fewer so that sdin_s[1] lines up with the edge seen on sclk_s[2:1]
    always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
        if (reset) begin
            sclk_s  <= '0;
            lrclk_s <= '0;
            sdin_s  <= '0;
        end else begin
            sclk_s  <= {sclk_s[1:0], sclk};
            lrclk_s <= {lrclk_s[1:0], lrclk};
            sdin_s  <= {sdin_s[0], sdin};
        end
    end

    assign sclk_rise = sclk_s[1] & ~sclk_s[2];
    assign lr_rise   = lrclk_s[1] & ~lrclk_s[2];
    assign lr_fall   = ~lrclk_s[1] & lrclk_s[2];
    assign bit_in    = sdin_s[1];

    always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // An LRCLK edge beats a coincident SCLK rise, which then serves as the delay bit
    always_comb begin
        state_nxt  = state;
        slot_start = 1'b0;
        latch_l    = 1'b0;
        latch_r    = 1'b0;
        shift_en   = 1'b0;
        if (!enable)
            state_nxt = IDLE;
        else
            case (state)
                IDLE: if (lr_fall) begin
                    slot_start = 1'b1;
                    state_nxt  = sclk_rise ? LEFT : SKIP_L;
                end
                SKIP_L, LEFT: if (lr_rise) begin
                    latch_l    = 1'b1;
                    slot_start = 1'b1;
                    state_nxt  = sclk_rise ? RIGHT : SKIP_R;
                end else if (sclk_rise) begin
                    shift_en  = state == LEFT;
                    state_nxt = LEFT;
                end
                SKIP_R, RIGHT: if (lr_fall) begin
                    latch_r    = 1'b1;
                    slot_start = 1'b1;
                    state_nxt  = sclk_rise ? LEFT : SKIP_L;
                end else if (sclk_rise) begin
                    shift_en  = state == RIGHT;
                    state_nxt = RIGHT;
                end
                default: state_nxt = IDLE;
            endcase
    end

    assign bit_pos = CNT_W'(SAMPLE_W - 1) - bit_cnt;

    // Bits land MSB-first at fixed positions, so a short slot is left-justified with zero LSBs
    always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
        if (reset) begin
            shreg   <= '0;
            bit_cnt <= '0;
            left_q  <= '0;
            right_q <= '0;
            push_q  <= 1'b0;
        end else begin
            push_q <= latch_r;
            if (latch_l)
                left_q <= shreg;
            if (latch_r)
                right_q <= shreg;
            if (slot_start) begin
                shreg   <= '0;
                bit_cnt <= '0;
            end else if (shift_en && bit_cnt < CNT_W'(SAMPLE_W)) begin
                shreg[bit_pos] <= bit_in;
                bit_cnt        <= bit_cnt + CNT_W'(1);
            end
        end
    end

    assign valid    = count != '0;
    assign full     = count == (PTR_W + 1)'(FIFO_DEPTH);
    assign pop      = valid & ready;
    assign push_ok  = push_q & (~full | pop);
    assign sample_l = valid ? mem_l[rd_ptr] : '0;
    assign sample_r = valid ? mem_r[rd_ptr] : '0;

    always_ff @(posedge MAX10_CLK1_50) begin
        if (push_ok) begin
            mem_l[wr_ptr] <= left_q;
            mem_r[wr_ptr] <= right_q;
        end
    end

    // A pop from a full FIFO frees the slot that a same-cycle push then takes
    always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (push_ok && !pop)
                count <= count + (PTR_W + 1)'(1);
            else if (pop && !push_ok)
                count <= count - (PTR_W + 1)'(1);
            overrun <= (push_q & ~push_ok) | (overrun & ~clear_ovr);
        end
    end

`ifdef I2S_RX_FRAME_CTR_EN
    always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
        if (reset)
            frame_ctr <= '0;
        else if (push_ok)
            frame_ctr <= frame_ctr + 16'd1;
    end
`endif

endmodule

// File: doc/i2s_rx_capture.md
# i2s_rx_capture

I2S receiver for the audio codec's ADC path, the capture-side counterpart of the playback serializer. The codec stays bus master and drives SCLK (bit clock) and LRCLK (word select) into the FPGA on Arduino header pins. This block synchronizes those pins and the codec's serial data into the 50 MHz system clock, then deserializes left/right slots. Completed stereo frames go into a small FIFO and are presented over a valid/ready handshake to downstream fabric (SDRAM writer, level meter).

## Interface
- SAMPLE_W, 16: bits kept per channel, taken MSB-first from each slot; legal range 8–32.
- FIFO_DEPTH, 4: stereo frames buffered; power of two, at least 2.
- Clk  input  1  system clock (MAX10_CLK1_50, 50 MHz).
- Reset  input  1  asynchronous, active-high reset.
- Enable  input  1  capture enable; low forces IDLE.
- SCLK  input  1  codec bit clock, asynchronous to Clk, at most 6.25 MHz.
- LRCLK  input  1  codec word select, asynchronous; low = left, high = right.
- SDIN  input  1  codec ADC serial data, asynchronous.
- Ready  input  1  downstream accepts the head frame.
- Clear_ovr  input  1  clears Overrun.
- Sample_L  output  SAMPLE_W  left sample of the head frame.
- Sample_R  output  SAMPLE_W  right sample of the head frame.
- Valid  output  1  FIFO not empty.
- Overrun  output  1  sticky; a frame was dropped.
- Frame_ctr  output  16  frames pushed (exists only with I2S_RX_FRAME_CTR_EN).

## Operation
- Synchronization: SCLK, LRCLK and SDIN each pass through a 2-flop synchronizer. A third register on SCLK and LRCLK provides edge detection. All three signals are delayed equally, so bits are sampled with their own SCLK edge.
- Bit sampling happens on a detected rising SCLK edge. Standard I2S framing applies: the MSB comes one SCLK after an LRCLK transition.
- FSM states: IDLE, SKIP_L, LEFT, SKIP_R, RIGHT.
  - IDLE to SKIP_L on a falling LRCLK edge while Enable is high. Alignment always starts on a left slot.
  - SKIP_L to LEFT on the next rising SCLK, which is the delay bit and is discarded.
  - LEFT shifts in bits while bit_cnt < SAMPLE_W; later bits in the slot are ignored.
  - LEFT to SKIP_R on a rising LRCLK edge, which latches the left shift register.
  - SKIP_R to RIGHT after one rising SCLK, mirroring SKIP_L.
  - RIGHT to SKIP_L on a falling LRCLK edge. This latches the right sample and pushes the {L,R} pair.
- Short slot: if LRCLK toggles before SAMPLE_W bits have been captured, the missing LSBs are zero. The sample is left-justified.
- An LRCLK edge and an SCLK rising edge detected in the same Clk cycle: the LRCLK edge wins and the state transition happens. That SCLK edge counts as the delay bit.
- FIFO push and pop:
  - Pop occurs when Valid and Ready are both high.
  - A push into a full FIFO drops the new frame, leaves the contents unchanged and sets Overrun.
  - If push and pop fall in the same cycle while the FIFO is full, the pop happens first and the push succeeds. No overrun is flagged.
- Overrun: Clear_ovr clears it. A simultaneous set and clear leaves it set.
- Enable low: the FSM goes to IDLE immediately and any partial frame is discarded. FIFO contents remain poppable. Re-enabling waits for the next falling LRCLK edge.
- Sample_L and Sample_R are driven combinationally from the FIFO head and are stable while Valid is high and Ready is low.

## Timing
- Reset values:
  - Valid = 0, Overrun = 0.
  - Sample_L and Sample_R = 0.
  - Frame_ctr = 0, with FIFO pointers and count also 0.
  - FSM in IDLE, and all synchronizer flops 0.
- Input-to-detect latency is 3 Clk cycles from a pin edge to the internal edge pulse, ±1 for metastability.
- Push happens the cycle after the falling-LRCLK detect pulse. Valid rises the cycle after the push, so Valid rises at most 5 Clk cycles after the raw LRCLK falling edge.
- Pop takes effect at the clock edge where Valid and Ready are both high. The next head, or Valid = 0, appears the following cycle. Full throughput is one frame per cycle.
- Minimum SCLK high and low time is 4 Clk cycles.

## Configuration
- I2S_RX_FRAME_CTR_EN
  - Defined: Frame_ctr is present. It increments by 1 on each successful push, wraps from 0xFFFF to 0, does not count dropped frames, and resets to 0.
  - Undefined: the port and its logic are omitted and all other behaviour is identical.

## Test plan
- Reset check: assert Reset mid-frame, release it, and idle 10 cycles, giving Valid=0, Overrun=0, Sample_L=Sample_R=0 and Frame_ctr=0. Then drive one 32-bit-slot frame with L=0xA5C3 and R=0x1234 in the top 16 bits, giving Valid high within 5 cycles of the falling LRCLK and Sample_L=0xA5C3, Sample_R=0x1234.
- Back-to-back with Ready held high: 3 frames with L=0x0001/0x0002/0x0003, giving 3 pops in order, Valid low between frames, and Frame_ctr=3 with the macro defined.
- Overrun: Ready low and 5 frames with FIFO_DEPTH=4, giving FIFO frames 1–4, Overrun=1, and frame 5 lost. Asserting Clear_ovr then gives Overrun=0. Popping 4 frames returns frames 1–4.
- Short slot: LRCLK toggles after 12 data bits 0xABC, giving Sample_L=0xABC0.
- Enable drop: Enable goes low halfway through the right slot, giving no push for that frame. Re-enable lined up mid-left-slot gives no push until a complete aligned frame arrives, then a correct capture.
- Full with simultaneous push and pop: FIFO full, Ready high on the push cycle, giving Overrun=0 and the new frame stored as the last entry.
